reg_access_ctrl: RTL

- Initiator side of the CPU register-file interface in the multicycle MIPS datapath.
- Accepts an instruction word and drives the register-file read addresses (rs, rt). Latches the read data into operand registers A and B and presents them to the ALU/control stage with a handshake.
- Later accepts a writeback request, selects the destination (rt, rd or link register) and drives a single-cycle write strobe to the register file.
- The register file reads combinationally and writes on the falling clock edge.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/reg_access_ctrl_if.sv | 39 +++
 rtl/reg_access_ctrl_fwd_mux.sv | 26 ++
 rtl/reg_access_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the register-access controller: writeback selects,
// FSM state codes and instruction field positions.
package cpu_pkg;

    localparam logic [1:0] WB_RT   = 2'b00;
    localparam logic [1:0] WB_RD   = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;
    localparam logic [1:0] WB_NONE = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_OPS   = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;

endpackage

// File: rtl/reg_access_ctrl_if.sv
// Bundle of instruction, operand, writeback and register-file signals.
// master = the controller, slave = its surroundings (decoder, ALU, register file).
interface reg_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic              instr_ready;
    logic [REG_AW-1:0] rf_src1;
    logic [REG_AW-1:0] rf_src2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_valid;
    logic              op_ack;
    logic              wb_valid;
    logic [1:0]        wb_sel;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;
    logic [REG_AW-1:0] rf_dest;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic              busy;

    modport master (
        input  instr_valid, instr, rf_rdata1, rf_rdata2, op_ack, wb_valid, wb_sel, wb_data,
        output instr_ready, rf_src1, rf_src2, op_a, op_b, op_valid, wb_ready,
               rf_dest, rf_wdata, rf_we, busy
    );

    modport slave (
        output instr_valid, instr, rf_rdata1, rf_rdata2, op_ack, wb_valid, wb_sel, wb_data,
        input  instr_ready, rf_src1, rf_src2, op_a, op_b, op_valid, wb_ready,
               rf_dest, rf_wdata, rf_we, busy
    );

endinterface

// File: rtl/reg_access_ctrl_fwd_mux.sv
// reg_fwd_mux: swaps in the last written value on a read-address match (REG_ACCESS_B2B_EN only).
// Latency: combinational. Backpressure: none.
// Register 0 never matches, so a suppressed r0 write is never forwarded.
`ifdef REG_ACCESS_B2B_EN
module reg_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic              fwd_vld,
    input  logic [REG_AW-1:0] fwd_dest,
    input  logic [DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2
);
    logic fwd_live;

    assign fwd_live = fwd_vld && (fwd_dest != '0);
    assign out1     = (fwd_live && (src1 == fwd_dest)) ? fwd_data : rdata1;
    assign out2     = (fwd_live && (src2 == fwd_dest)) ? fwd_data : rdata2;

endmodule
`endif

// File: rtl/reg_access_ctrl.sv
// Register-file initiator: latches operands A/B, then issues one writeback. Optional REG_ACCESS_B2B_EN.
// Latency: instr accept -> op_valid 2 cycles; wb accept -> rf_we 1 cycle; period 5 (4 with B2B).
// Backpressure: instr_ready/op_valid/wb_ready only in their own state; requests elsewhere are dropped.
module reg_access_ctrl
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    reg_access_ctrl_if.master bus
);
    localparam logic [REG_AW-1:0] LINK_IDX = REG_AW'(LINK_REG);

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [REG_AW-1:0] rf_dest_q, rf_dest_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [REG_AW-1:0] ir_rs, ir_rt, ir_rd;
    logic [DATA_W-1:0] rd1, rd2;
    logic              instr_acc;
    logic              unused_ir;

    assign ir_rs     = ir_q[RS_LSB +: REG_AW];
    assign ir_rt     = ir_q[RT_LSB +: REG_AW];
    assign ir_rd     = ir_q[RD_LSB +: REG_AW];
    assign unused_ir = ^{ir_q[DATA_W-1:RS_LSB+REG_AW], ir_q[RD_LSB-1:0]};
    assign instr_acc = bus.instr_valid && bus.instr_ready;

`ifdef REG_ACCESS_B2B_EN
    logic              fwd_vld_q, fwd_vld_d;
    logic [REG_AW-1:0] fwd_dest_q, fwd_dest_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

    reg_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd (
        .src1     (ir_rs),
        .src2     (ir_rt),
        .rdata1   (bus.rf_rdata1),
        .rdata2   (bus.rf_rdata2),
        .fwd_vld  (fwd_vld_q),
        .fwd_dest (fwd_dest_q),
        .fwd_data (fwd_data_q),
        .out1     (rd1),
        .out2     (rd2)
    );

    assign bus.instr_ready = (state_q == ST_IDLE) || (state_q == ST_WRITE);
`else
    assign rd1             = bus.rf_rdata1;
    assign rd2             = bus.rf_rdata2;
    assign bus.instr_ready = (state_q == ST_IDLE);
`endif

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        rf_dest_d  = rf_dest_q;
        rf_wdata_d = rf_wdata_q;
`ifdef REG_ACCESS_B2B_EN
        fwd_vld_d  = fwd_vld_q;
        fwd_dest_d = fwd_dest_q;
        fwd_data_d = fwd_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (instr_acc) begin
                    ir_d    = bus.instr;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                op_a_d  = rd1;
                op_b_d  = rd2;
                state_d = ST_OPS;
            end
            ST_OPS: begin
                if (bus.op_ack) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (bus.wb_valid) begin
                    rf_wdata_d = bus.wb_data;
                    state_d    = ST_WRITE;
                    case (bus.wb_sel)
                        WB_RT:   rf_dest_d = ir_rt;
                        WB_RD:   rf_dest_d = ir_rd;
                        WB_LINK: rf_dest_d = LINK_IDX;
                        default: begin
                            state_d = ST_IDLE;
`ifdef REG_ACCESS_B2B_EN
                            fwd_vld_d = 1'b0;
`endif
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
`ifdef REG_ACCESS_B2B_EN
                fwd_vld_d  = 1'b1;
                fwd_dest_d = rf_dest_q;
                fwd_data_d = rf_wdata_q;
                // Chained instruction skips IDLE; its READ may hit this write.
                if (instr_acc) begin
                    ir_d    = bus.instr;
                    state_d = ST_READ;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ir_q       <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            rf_dest_q  <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            rf_dest_q  <= rf_dest_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

`ifdef REG_ACCESS_B2B_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_vld_q  <= 1'b0;
            fwd_dest_q <= '0;
            fwd_data_q <= '0;
        end else begin
            fwd_vld_q  <= fwd_vld_d;
            fwd_dest_q <= fwd_dest_d;
            fwd_data_q <= fwd_data_d;
        end
    end
`endif

    // rf_we decodes straight from state so an async reset kills a write in flight.
    assign bus.rf_src1  = ir_rs;
    assign bus.rf_src2  = ir_rt;
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.op_valid = (state_q == ST_OPS);
    assign bus.wb_ready = (state_q == ST_EXEC);
    assign bus.rf_dest  = rf_dest_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.rf_we    = (state_q == ST_WRITE) && (rf_dest_q != '0);
    assign bus.busy     = (state_q != ST_IDLE);

endmodule
